// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   - Valid_2IF encodings seen by the fetch stage
//   - FSM state encoding of the refill controller
//   - processor reset vector (first fetch address after reset)
package imem_pkg;

    localparam logic [1:0] IMEM_WAIT     = 2'd0;
    localparam logic [1:0] IMEM_VALID    = 2'd1;
    localparam logic [1:0] IMEM_MISALIGN = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/icache_line_array.sv
// Storage for the direct-mapped instruction cache.
//   clk, rst_n      : clock, async active-low reset (clears valid bits only)
//   flush           : clear every valid bit on this edge (wins over a line install)
//   rd_index/offset : async read port -> rd_valid, rd_tag, rd_word
//   wr_word_en      : write wr_data into word wr_offset of line wr_index
//   wr_line_en      : write wr_tag and set the valid bit of wr_index to wr_line_valid
module icache_line_array #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 22
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [$clog2(LINES)-1:0]          rd_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_offset,
    output logic                              rd_valid,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [31:0]                       rd_word,
    input  logic                              wr_word_en,
    input  logic [$clog2(LINES)-1:0]          wr_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_offset,
    input  logic [31:0]                       wr_data,
    input  logic                              wr_line_en,
    input  logic [TAG_W-1:0]                  wr_tag,
    input  logic                              wr_line_valid
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES*WORDS_PER_LINE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_line_en) begin
            valid_q[wr_index] <= wr_line_valid;
        end
    end

    // Tag and data are not reset; the valid bits alone decide a hit.
    always_ff @(posedge clk) begin
        if (wr_line_en) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (wr_word_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped blocking instruction cache between the fetch stage and memory.
//   CLK, RESET        : clock, async active-low reset
//   Instr_address_fIF : fetch byte address
//   Instr1_2IF        : instruction (0 unless Valid_2IF == IMEM_VALID)
//   Valid_2IF         : IMEM_WAIT / IMEM_VALID / IMEM_MISALIGN
//   Flush             : invalidate all lines
//   Mem_Req/Mem_Addr  : registered line-fill request, held until Mem_Gnt
//   Mem_Gnt           : request accepted (only looked at in REQ)
//   Mem_RValid/RData  : fill beats, ascending word order (only looked at in FILL)
// Hits are answered combinationally in IDLE; misses refill a whole line.
module icache_responder
    import imem_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr_address_fIF,
    output logic [31:0] Instr1_2IF,
    output logic [1:0]  Valid_2IF,
    input  logic        Flush,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Gnt,
    input  logic        Mem_RValid,
    input  logic [31:0] Mem_RData
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_W   = 32 - 2 - OFF_W - IDX_W;
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;

    localparam logic [31:0]      LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    logic [1:0]       state;
    logic [OFF_W-1:0] beat_cnt;
    logic             flush_seen;

    logic [OFF_W-1:0] addr_offset;
    logic [IDX_W-1:0] addr_index;
    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_word;

    logic             misaligned;
    logic             hit;
    logic             beat_accept;
    logic             last_beat;

    assign addr_offset = Instr_address_fIF[2 +: OFF_W];
    assign addr_index  = Instr_address_fIF[IDX_LSB +: IDX_W];
    assign addr_tag    = Instr_address_fIF[TAG_LSB +: TAG_W];

    // The line being filled is identified by the latched request address,
    // so a redirect of the fetch address mid-burst cannot corrupt the install.
    assign fill_index = Mem_Addr[IDX_LSB +: IDX_W];
    assign fill_tag   = Mem_Addr[TAG_LSB +: TAG_W];

    assign misaligned  = |Instr_address_fIF[1:0];
    assign hit         = rd_valid && (rd_tag == addr_tag);
    assign beat_accept = (state == ST_FILL) && Mem_RValid;
    assign last_beat   = beat_accept && (beat_cnt == LAST_BEAT);

    icache_line_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_lines (
        .clk           (CLK),
        .rst_n         (RESET),
        .flush         (Flush),
        .rd_index      (addr_index),
        .rd_offset     (addr_offset),
        .rd_valid      (rd_valid),
        .rd_tag        (rd_tag),
        .rd_word       (rd_word),
        .wr_word_en    (beat_accept),
        .wr_index      (fill_index),
        .wr_offset     (beat_cnt),
        .wr_data       (Mem_RData),
        .wr_line_en    (last_beat),
        .wr_tag        (fill_tag),
        // A flush anywhere in the burst (including the last-beat edge) leaves
        // the line invalid; the array also lets Flush override the install.
        .wr_line_valid (!(flush_seen || Flush))
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            flush_seen <= 1'b0;
            Mem_Req    <= 1'b0;
            Mem_Addr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!misaligned && !hit) begin
                        state    <= ST_REQ;
                        Mem_Req  <= 1'b1;
                        Mem_Addr <= Instr_address_fIF & ~LINE_MASK;
                    end
                end
                ST_REQ: begin
                    if (Mem_Gnt) begin
                        state      <= ST_FILL;
                        Mem_Req    <= 1'b0;
                        beat_cnt   <= '0;
                        flush_seen <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (Flush) begin
                        flush_seen <= 1'b1;
                    end
                    if (Mem_RValid) begin
                        beat_cnt <= beat_cnt + OFF_W'(1);
                        if (last_beat) begin
                            state    <= ST_IDLE;
                            beat_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    Mem_Req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        Valid_2IF  = IMEM_WAIT;
        Instr1_2IF = '0;
        if (RESET && (state == ST_IDLE)) begin
            if (misaligned) begin
                Valid_2IF = IMEM_MISALIGN;
            end else if (hit) begin
                Valid_2IF  = IMEM_VALID;
                Instr1_2IF = rd_word;
            end
        end
    end

endmodule

// File: doc/icache_responder.md
# icache_responder

Instruction-memory responder serving the fetch stage's `Instr_address_2IM` / `Instr1_fIM` / `Valid` interface.
- Direct-mapped, blocking instruction cache with a same-cycle (combinational) hit path, which the fetch stage needs because it samples instruction and `Valid` on the same edge it presents the address.
- On a miss it drives `Valid=0` and refills one line from backing memory over a request/grant plus in-order-beat interface, then returns the instruction.
- Sits between the IF stage and the memory model.

## Interface
- `LINES`, 64, number of cache lines (power of two).
- `WORDS_PER_LINE`, 4, 32-bit words per line (power of two, ≥2).
- `CLK`  in  1  single clock, rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `Instr_address_fIF`  in  32  byte address requested by fetch.
- `Instr1_2IF`  out  32  instruction word; 0 unless `Valid_2IF==1`.
- `Valid_2IF`  out  2  0 = waiting, 1 = instruction valid, 2 = misaligned address; 3 is never driven.
- `Flush`  in  1  invalidate all lines.
- `Mem_Req`  out  1  line-fill request, held until granted.
- `Mem_Addr`  out  32  line-aligned fill address.
- `Mem_Gnt`  in  1  memory accepts request (sampled while `Mem_Req=1`).
- `Mem_RValid`  in  1  fill beat valid.
- `Mem_RData`  in  32  fill beat data, words in ascending order.

## Operation
- Address split (defaults): offset [3:2], index [9:4], tag [31:10]; widths are derived from parameters via log2.
- Storage per line: valid bit, tag, `WORDS_PER_LINE` data words.
- Reads are asynchronous; writes are synchronous.
- States: IDLE, REQ, FILL.
- IDLE:
  - Address[1:0]≠0 → `Valid_2IF=2`, `Instr1_2IF=0`, no fill.
  - Hit (valid and tag match) → `Valid_2IF=1`, `Instr1_2IF` = word[offset].
  - Miss → `Valid_2IF=0`; latch line base (address with offset and byte bits cleared); go to REQ.
- REQ: `Mem_Req=1`, `Mem_Addr` = latched base. On `Mem_Gnt=1`, go to FILL with beat counter=0.
- FILL: each `Mem_RValid` writes data word[counter] and increments the counter. On the last beat, write tag, set valid, go to IDLE.
- `Valid_2IF=0` in REQ and FILL regardless of address (blocking cache).
- Address changes mid-fill (branch redirect): the burst always completes and the line is installed; the new address is evaluated in IDLE.
- `Mem_RValid` outside FILL is ignored; `Mem_Gnt` outside REQ is ignored.
- `Flush` in any state clears all valid bits on that edge.
  - `Flush` during FILL: the fill completes but the line is NOT marked valid.
  - `Flush` on the same edge as the last beat: the line is not valid.
- `RESET` low in any state, including mid-fill:
  - state → IDLE, counter → 0, all valid bits → 0.
  - `Mem_Req` → 0, `Mem_Addr` → 0.
  - `Valid_2IF` → 0 and `Instr1_2IF` → 0 for as long as reset is asserted.
  - Data and tag arrays are not reset.

## Timing
- Hit latency is 0 cycles: outputs are combinational from the address in IDLE.
- `Mem_Req` and `Mem_Addr` are registered (Moore).
- Miss detected at edge N → `Mem_Req=1` from cycle N+1.
- With `Mem_Gnt` in cycle N+1 and 4 back-to-back beats in N+2..N+5 → state IDLE and `Valid_2IF=1` in cycle N+6. Minimum miss penalty is 6 cycles.
- Gaps between beats are allowed; the counter only advances on `Mem_RValid`.
- `Mem_Req` drops in the cycle after the `Mem_Gnt` edge.

## Structure
- Shared package `imem_pkg`: `Valid` encodings (`IMEM_WAIT`=0, `IMEM_VALID`=1, `IMEM_MISALIGN`=2), FSM state encoding, reset vector `32'hBFC00000`.
- Sub-module `icache_line_array`: valid, tag and data storage with async read port, sync line/word write port and a flush-all input.
- FSM, counter and hit/miss compare live in the top module.

## Test plan
- Cold fetch at BFC00000 → `Valid_2IF=0`. `Mem_Req=1` with `Mem_Addr=BFC00000`. Gnt plus beats 11,22,33,44 → `Valid_2IF=1`, `Instr1_2IF=0x11`. Then BFC00004/8/C return 22/33/44 with 0-cycle latency.
- Address BFC00002 → `Valid_2IF=2`, `Instr1_2IF=0`, `Mem_Req` stays 0.
- Conflict: fill BFC00000, then fetch BFC00400 (same index 0, tag differs) → miss and refill. A return to BFC00000 misses again.
- Redirect mid-fill: address changes to 80000000 during FILL of BFC00000. The fill completes and BFC00000 hits later; a 80000000 miss starts in the cycle after IDLE.
- `Flush` pulsed on the last-beat edge → the next access to that line misses. `Flush` while idle after a fill → the next access misses.
- `RESET` low mid-FILL after 2 beats → `Mem_Req=0`, `Valid_2IF=0`. After release, BFC00000 misses and a fresh 4-beat fill is requested.
